// File: rtl/i2c_target_if.sv
// I2C target signal bundle: pad-side SCL/SDA plus the byte-level client handshake.
// The target uses the slave modport; a bench or client model uses the master modport.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled START/STOP detection, 7-bit address match,
// write-byte delivery, read-byte fetch and open-drain (low-only) SDA drive.
module i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic         clk,
    input  logic         rst,
    i2c_target_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WRITE    = 3'd3,
        WR_ACK   = 3'd4,
        READ     = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] tx_shift_q, tx_shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;
    logic       busy_q, busy_d;

    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;
    logic scl_rise_s, scl_fall_s, start_cond_s, stop_cond_s;

    // Two-flop synchronisers plus one history flop; idle-high reset avoids false edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= bus.scl_in;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= bus.sda_in;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
        end
    end

    assign scl_rise_s   = scl_sync_q & ~scl_hist_q;
    assign scl_fall_s   = ~scl_sync_q & scl_hist_q;
    assign start_cond_s = scl_sync_q & ~sda_sync_q & sda_hist_q;
    assign stop_cond_s  = scl_sync_q & sda_sync_q & ~sda_hist_q;

    // Protocol state register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= 4'd0;
            shift_q     <= 7'd0;
            tx_shift_q  <= 7'd0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: START/STOP win over every state; data moves on SCL edges only.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        busy_d      = busy_q;

        if (start_cond_s) begin
            state_d     = ADDR;
            bitcnt_d    = 4'd0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            start_det_d = 1'b1;
        end else if (stop_cond_s) begin
            state_d    = IDLE;
            bitcnt_d   = 4'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                    bitcnt_d = 4'd0;
                end
                ADDR: begin
                    if (scl_rise_s) begin
                        shift_d  = {shift_q[5:0], sda_sync_q};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            rw_d = sda_sync_q;
                            if (shift_q != SLAVE_ADDR) begin
                                state_d  = IGNORE;
                                bitcnt_d = 4'd0;
                            end else begin
                                state_d = ADDR;
                            end
                        end else begin
                            rw_d = rw_q;
                        end
                    end else if (scl_fall_s && (bitcnt_q == 4'd8)) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        bitcnt_d = 4'd0;
                        tx_req_d = rw_q;
                        state_d  = ADDR_ACK;
                    end else begin
                        state_d = ADDR;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        bitcnt_d = 4'd0;
                        if (rw_q) begin
                            tx_shift_d = bus.tx_data[6:0];
                            sda_oe_d   = ~bus.tx_data[7];
                            state_d    = READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WRITE;
                        end
                    end else begin
                        state_d = ADDR_ACK;
                    end
                end
                WRITE: begin
                    if (scl_rise_s) begin
                        shift_d  = {shift_q[5:0], sda_sync_q};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            rx_data_d  = {shift_q, sda_sync_q};
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_valid_d = 1'b0;
                        end
                    end else if (scl_fall_s && (bitcnt_q == 4'd8)) begin
                        sda_oe_d = 1'b1;
                        bitcnt_d = 4'd0;
                        state_d  = WR_ACK;
                    end else begin
                        state_d = WRITE;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 4'd0;
                        state_d  = WRITE;
                    end else begin
                        state_d = WR_ACK;
                    end
                end
                READ: begin
                    if (scl_rise_s) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall_s && (bitcnt_q == 4'd8)) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 4'd0;
                        state_d  = RD_ACK;
                    end else if (scl_fall_s && (bitcnt_q != 4'd0)) begin
                        sda_oe_d   = ~tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[5:0], 1'b0};
                    end else begin
                        state_d = READ;
                    end
                end
                RD_ACK: begin
                    // bitcnt 1 marks a controller ACK awaiting the next falling edge.
                    if (scl_rise_s) begin
                        if (!sda_sync_q) begin
                            tx_req_d = 1'b1;
                            bitcnt_d = 4'd1;
                        end else begin
                            busy_d   = 1'b0;
                            bitcnt_d = 4'd0;
                            state_d  = IGNORE;
                        end
                    end else if (scl_fall_s && (bitcnt_q == 4'd1)) begin
                        tx_shift_d = bus.tx_data[6:0];
                        sda_oe_d   = ~bus.tx_data[7];
                        bitcnt_d   = 4'd0;
                        state_d    = READ;
                    end else begin
                        state_d = RD_ACK;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                    bitcnt_d = 4'd0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                    bitcnt_d = 4'd0;
                end
            endcase
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_req    = tx_req_q;
    assign bus.start_det = start_det_q;
    assign bus.stop_det  = stop_det_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level I2C controller model drives an
// open-drain line and checks ACKs, received bytes, read data and event pulses.
module tb_i2c_target;

    localparam int H = 16;

    logic clk = 1'b0;
    logic rst;
    logic ctl_scl;
    logic ctl_sda_low;

    int checks = 0;
    int errors = 0;

    int n_start = 0;
    int n_stop  = 0;
    int n_rxv   = 0;
    int n_txreq = 0;
    int n_oe    = 0;
    int n_busy  = 0;
    logic [7:0] rx_log[$];

    i2c_target_if bus ();

    always #5 clk = ~clk;

    assign bus.scl_in = ctl_scl;
    assign bus.sda_in = ~(bus.sda_oe | ctl_sda_low);

    i2c_target #(.SLAVE_ADDR(7'h50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Event monitor: counts pulse cycles and logs every delivered byte.
    always @(negedge clk) begin
        if (bus.start_det) n_start <= n_start + 1;
        if (bus.stop_det)  n_stop  <= n_stop + 1;
        if (bus.tx_req)    n_txreq <= n_txreq + 1;
        if (bus.sda_oe)    n_oe    <= n_oe + 1;
        if (bus.busy)      n_busy  <= n_busy + 1;
        if (bus.rx_valid) begin
            rx_log.push_back(bus.rx_data);
            n_rxv <= n_rxv + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        ctl_sda_low = 1'b1;
        wait_clk(H);
        ctl_scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        wait_clk(H / 2);
        ctl_sda_low = 1'b0;
        wait_clk(H / 2);
        ctl_scl = 1'b1;
        wait_clk(H);
        ctl_sda_low = 1'b1;
        wait_clk(H);
        ctl_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(H / 2);
        ctl_sda_low = 1'b1;
        wait_clk(H / 2);
        ctl_scl = 1'b1;
        wait_clk(H);
        ctl_sda_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(H / 2);
        ctl_sda_low = ~b;
        wait_clk(H / 2);
        ctl_scl = 1'b1;
        wait_clk(H);
        ctl_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(H / 2);
        ctl_sda_low = 1'b0;
        wait_clk(H / 2);
        ctl_scl = 1'b1;
        wait_clk(H / 2);
        b = bus.sda_in;
        wait_clk(H / 2);
        ctl_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_sda_oe"},    32'(bus.sda_oe),    32'h0);
        check({pfx, "_rx_data"},   32'(bus.rx_data),   32'h0);
        check({pfx, "_rx_valid"},  32'(bus.rx_valid),  32'h0);
        check({pfx, "_tx_req"},    32'(bus.tx_req),    32'h0);
        check({pfx, "_start_det"}, 32'(bus.start_det), 32'h0);
        check({pfx, "_stop_det"},  32'(bus.stop_det),  32'h0);
        check({pfx, "_busy"},      32'(bus.busy),      32'h0);
    endtask

    initial begin
        logic       ack;
        logic       bit_v;
        logic [7:0] rd0;
        logic [7:0] rd1;
        int b_start, b_stop, b_rxv, b_txreq, b_oe, b_busy;

        rst         = 1'b0;
        ctl_scl     = 1'b1;
        ctl_sda_low = 1'b0;
        bus.tx_data = 8'h00;
        wait_clk(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        wait_clk(5);

        // Write: A0, 3C, C3
        b_start = n_start; b_stop = n_stop; b_rxv = n_rxv;
        i2c_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'h1);
        check("wr_busy_after_addr", 32'(bus.busy), 32'h1);
        write_byte(8'h3C, ack);
        check("wr_d0_ack", 32'(ack), 32'h1);
        write_byte(8'hC3, ack);
        check("wr_d1_ack", 32'(ack), 32'h1);
        check("wr_busy_before_stop", 32'(bus.busy), 32'h1);
        i2c_stop();
        check("wr_rx_count", 32'(n_rxv - b_rxv), 32'd2);
        check("wr_rx0", 32'(rx_log[b_rxv]), 32'h3C);
        check("wr_rx1", 32'(rx_log[b_rxv + 1]), 32'hC3);
        check("wr_rx_hold", 32'(bus.rx_data), 32'hC3);
        check("wr_start_pulses", 32'(n_start - b_start), 32'd1);
        check("wr_stop_pulses", 32'(n_stop - b_stop), 32'd1);
        check("wr_busy_after_stop", 32'(bus.busy), 32'h0);

        // Read: 5A (ACK), 81 (NACK)
        b_txreq = n_txreq;
        bus.tx_data = 8'h5A;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'h1);
        check("rd_txreq_first", 32'(n_txreq - b_txreq), 32'd1);
        read_byte(rd0);
        check("rd_byte0", 32'(rd0), 32'h5A);
        bus.tx_data = 8'h81;
        write_bit(1'b0);
        check("rd_txreq_second", 32'(n_txreq - b_txreq), 32'd2);
        read_byte(rd1);
        check("rd_byte1", 32'(rd1), 32'h81);
        write_bit(1'b1);
        wait_clk(H / 2);
        check("rd_busy_after_nack", 32'(bus.busy), 32'h0);
        check("rd_oe_after_nack", 32'(bus.sda_oe), 32'h0);
        i2c_stop();

        // Address mismatch: A2, 11
        b_rxv = n_rxv; b_oe = n_oe; b_busy = n_busy;
        i2c_start();
        write_byte(8'hA2, ack);
        check("mm_addr_nack", 32'(ack), 32'h0);
        write_byte(8'h11, ack);
        check("mm_data_nack", 32'(ack), 32'h0);
        i2c_stop();
        check("mm_oe_cycles", 32'(n_oe - b_oe), 32'd0);
        check("mm_rx_count", 32'(n_rxv - b_rxv), 32'd0);
        check("mm_busy_cycles", 32'(n_busy - b_busy), 32'd0);

        // Repeated START: write 07, Sr, read 99
        b_start = n_start; b_stop = n_stop; b_rxv = n_rxv;
        bus.tx_data = 8'h99;
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_wr_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h07, ack);
        check("rs_wr_data_ack", 32'(ack), 32'h1);
        i2c_rstart();
        write_byte(8'hA1, ack);
        check("rs_rd_addr_ack", 32'(ack), 32'h1);
        read_byte(rd0);
        write_bit(1'b1);
        i2c_stop();
        check("rs_rx_data", 32'(bus.rx_data), 32'h07);
        check("rs_rx_count", 32'(n_rxv - b_rxv), 32'd1);
        check("rs_start_pulses", 32'(n_start - b_start), 32'd2);
        check("rs_stop_pulses", 32'(n_stop - b_stop), 32'd1);
        check("rs_read_byte", 32'(rd0), 32'h99);

        // Abort after 4 data bits, then a clean write of 5E
        b_rxv = n_rxv;
        i2c_start();
        write_byte(8'hA0, ack);
        check("ab_addr_ack", 32'(ack), 32'h1);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        i2c_stop();
        check("ab_rx_count", 32'(n_rxv - b_rxv), 32'd0);
        check("ab_oe", 32'(bus.sda_oe), 32'h0);
        check("ab_busy", 32'(bus.busy), 32'h0);
        i2c_start();
        write_byte(8'hA0, ack);
        check("ab_next_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h5E, ack);
        check("ab_next_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        check("ab_next_rx_count", 32'(n_rxv - b_rxv), 32'd1);
        check("ab_next_rx_data", 32'(bus.rx_data), 32'h5E);

        // Async reset mid read byte while the target pulls SDA low
        bus.tx_data = 8'h3F;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rr_addr_ack", 32'(ack), 32'h1);
        read_bit(bit_v);
        check("rr_bit7", 32'(bit_v), 32'h0);
        wait_clk(H / 2);
        check("rr_oe_before_reset", 32'(bus.sda_oe), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("rr_oe_async", 32'(bus.sda_oe), 32'h0);
        check_reset_outputs("rr_reset");
        ctl_sda_low = 1'b0;
        ctl_scl     = 1'b1;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(8);
        b_rxv = n_rxv;
        i2c_start();
        write_byte(8'hA0, ack);
        check("rr_post_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h42, ack);
        check("rr_post_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        check("rr_post_rx_count", 32'(n_rxv - b_rxv), 32'd1);
        check("rr_post_rx_data", 32'(bus.rx_data), 32'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
